// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: types and constants shared by the instruction-fetch controller.
//   fetch_state_t    - main fetch FSM states
//   pf_state_t       - prefetch tracker states (FETCH_SKID_EN builds only)
//   PC_RESET_DEFAULT - default reset PC
//   pc_next()        - sequential next-instruction PC
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    HOLD,
    DISCARD
  } fetch_state_t;

  typedef enum logic [1:0] {
    PF_NONE,
    PF_ADDR,
    PF_DATA
  } pf_state_t;

  localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;

  function automatic logic [63:0] pc_next(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-bus handshake between the fetch controller and memory.
//   ireq_valid/ireq_addr         - request, held until iresp_addr_ok
//   iresp_addr_ok                - address accepted this cycle
//   iresp_data_ok/iresp_data     - instruction word returned this cycle
// master = fetch controller, slave = bus/memory side.
interface fetch_ctrl_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok, iresp_data
  );

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok, iresp_data
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry buffer holding a prefetched instruction and its PC.
//   clk, reset (async, active low)
//   push_i/instr_i/pc_i - load an entry
//   pop_i               - consume the entry
//   flush_i             - drop the entry (wins over push/pop)
//   valid_o/instr_o/pc_o - current entry
module fetch_skid_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [63:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o
);
  logic        valid_q;
  logic [31:0] instr_q;
  logic [63:0] pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (push_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-issue instruction fetch controller.
//   clk, reset (async, active low)
//   ibus            - instruction bus (fetch_ctrl_if.master)
//   redirect_valid/redirect_pc - branch/exception redirect, highest priority
//   stall           - downstream cannot accept
//   out_valid/out_instr/out_pc - fetched instruction slot
// Misaligned PCs are not fetched; they are presented with out_instr=0 so the
// fetch stage raises the exception.
// Macro FETCH_SKID_EN: while stalled in HOLD, prefetch pc+4 into a one-entry
// skid buffer (fetch_skid_buf) so the next slot follows without a bus wait.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.master ibus,
  input  logic         redirect_valid,
  input  logic [63:0]  redirect_pc,
  input  logic         stall,
  output logic         out_valid,
  output logic [31:0]  out_instr,
  output logic [63:0]  out_pc
);
  fetch_state_t state_q;
  logic [63:0]  pc_q, ireq_addr_q, out_pc_q;
  logic [31:0]  out_instr_q;
  logic         ireq_valid_q, out_valid_q;
  logic         kill_q;    // redirect seen in ADDR; response of the old request must be dropped

  logic         xfer, launch_ok;
  logic [63:0]  seq_pc, nxt_pc, launch_pc;

  // prefetch view used by HOLD; all zero when prefetch is compiled out
  logic         sb_valid, pf_data, pf_wait_addr, pf_wait_data, pf_issue, pf_addr_acc;
  logic [31:0]  sb_instr;
  logic [63:0]  sb_pc;

  assign xfer      = out_valid_q & ~stall;
  assign seq_pc    = pc_next(out_pc_q);
  assign nxt_pc    = redirect_valid ? redirect_pc : pc_q;
  // where a new request goes: sequential after a transfer, otherwise the (redirect) pc
  assign launch_pc = (state_q == HOLD && !redirect_valid) ? seq_pc : nxt_pc;
  assign launch_ok = (launch_pc[1:0] == 2'b00);

`ifdef FETCH_SKID_EN
  pf_state_t pf_q;
  logic      sb_push, sb_pop, sb_flush;

  assign pf_data      = ibus.iresp_data_ok &
                        (((pf_q == PF_ADDR) & ibus.iresp_addr_ok) | (pf_q == PF_DATA));
  assign pf_addr_acc  = (pf_q == PF_ADDR) & ibus.iresp_addr_ok;
  assign pf_wait_addr = (pf_q == PF_ADDR) & ~ibus.iresp_addr_ok;
  assign pf_wait_data = (pf_q != PF_NONE) & ~pf_wait_addr & ~ibus.iresp_data_ok;
  assign pf_issue     = (pf_q == PF_NONE) & stall & ~sb_valid & (seq_pc[1:0] == 2'b00);
  assign sb_push      = (state_q == HOLD) & ~redirect_valid & ~xfer & pf_data;
  assign sb_pop       = (state_q == HOLD) & ~redirect_valid & xfer;
  assign sb_flush     = redirect_valid;

  // Prefetch lives only inside HOLD; leaving HOLD hands any in-flight
  // request to the main FSM (ADDR/DATA on transfer, ADDR/DISCARD on redirect).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pf_q <= PF_NONE;
    else if (state_q != HOLD || redirect_valid || xfer) pf_q <= PF_NONE;
    else begin
      case (pf_q)
        PF_NONE: if (pf_issue) pf_q <= PF_ADDR;
        PF_ADDR: if (ibus.iresp_addr_ok) pf_q <= ibus.iresp_data_ok ? PF_NONE : PF_DATA;
        PF_DATA: if (ibus.iresp_data_ok) pf_q <= PF_NONE;
        default: pf_q <= PF_NONE;
      endcase
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .reset   (reset),
    .push_i  (sb_push),
    .pop_i   (sb_pop),
    .flush_i (sb_flush),
    .instr_i (ibus.iresp_data),
    .pc_i    (seq_pc),
    .valid_o (sb_valid),
    .instr_o (sb_instr),
    .pc_o    (sb_pc)
  );
`else
  assign sb_valid     = 1'b0;
  assign sb_instr     = '0;
  assign sb_pc        = '0;
  assign pf_data      = 1'b0;
  assign pf_addr_acc  = 1'b0;
  assign pf_wait_addr = 1'b0;
  assign pf_wait_data = 1'b0;
  assign pf_issue     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pc_q         <= PC_RESET;
      kill_q       <= 1'b0;
      ireq_valid_q <= 1'b0;
      ireq_addr_q  <= '0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
    end else begin
      if (redirect_valid) begin
        pc_q        <= redirect_pc;
        out_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (!redirect_valid && !launch_ok) begin
            // misaligned: present a dummy slot carrying the faulting pc
            out_valid_q <= 1'b1;
            out_instr_q <= '0;
            out_pc_q    <= pc_q;
            state_q     <= HOLD;
          end else begin
            state_q      <= launch_ok ? ADDR : IDLE;
            ireq_valid_q <= launch_ok;
            ireq_addr_q  <= launch_pc;
          end
        end
        ADDR: begin
          // data_ok without addr_ok belongs to no request of ours: ignored
          if (ibus.iresp_addr_ok) begin
            ireq_valid_q <= 1'b0;
            kill_q       <= 1'b0;
            if (redirect_valid || kill_q) begin
              if (ibus.iresp_data_ok) begin
                state_q      <= launch_ok ? ADDR : IDLE;
                ireq_valid_q <= launch_ok;
                ireq_addr_q  <= launch_pc;
              end else begin
                state_q <= DISCARD;
              end
            end else if (ibus.iresp_data_ok) begin
              out_valid_q <= 1'b1;
              out_instr_q <= ibus.iresp_data;
              out_pc_q    <= pc_q;
              state_q     <= HOLD;
            end else begin
              state_q <= DATA;
            end
          end else if (redirect_valid) begin
            kill_q <= 1'b1;  // request stays on the bus unchanged
          end
        end
        DATA: begin
          if (redirect_valid) begin
            if (ibus.iresp_data_ok) begin
              state_q      <= launch_ok ? ADDR : IDLE;
              ireq_valid_q <= launch_ok;
              ireq_addr_q  <= launch_pc;
            end else begin
              state_q <= DISCARD;
            end
          end else if (ibus.iresp_data_ok) begin
            out_valid_q <= 1'b1;
            out_instr_q <= ibus.iresp_data;
            out_pc_q    <= pc_q;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            if (pf_wait_addr) begin
              state_q <= ADDR;
              kill_q  <= 1'b1;
            end else if (pf_wait_data) begin
              ireq_valid_q <= 1'b0;
              state_q      <= DISCARD;
            end else begin
              state_q      <= launch_ok ? ADDR : IDLE;
              ireq_valid_q <= launch_ok;
              ireq_addr_q  <= launch_pc;
            end
          end else if (xfer) begin
            pc_q        <= seq_pc;
            out_valid_q <= 1'b0;
            if (sb_valid) begin
              out_valid_q <= 1'b1;
              out_instr_q <= sb_instr;
              out_pc_q    <= sb_pc;
            end else if (pf_data) begin
              ireq_valid_q <= 1'b0;
              out_valid_q  <= 1'b1;
              out_instr_q  <= ibus.iresp_data;
              out_pc_q     <= seq_pc;
            end else if (pf_wait_addr) begin
              state_q <= ADDR;
            end else if (pf_wait_data) begin
              ireq_valid_q <= 1'b0;
              state_q      <= DATA;
            end else begin
              // chain straight into the next request, no idle bubble
              state_q      <= launch_ok ? ADDR : IDLE;
              ireq_valid_q <= launch_ok;
              ireq_addr_q  <= launch_pc;
            end
          end else if (pf_issue) begin
            ireq_valid_q <= 1'b1;
            ireq_addr_q  <= seq_pc;
          end else if (pf_addr_acc) begin
            ireq_valid_q <= 1'b0;
          end
        end
        DISCARD: begin
          // the dropped response frees the bus; a redirect here only moves pc
          if (ibus.iresp_data_ok) begin
            state_q      <= launch_ok ? ADDR : IDLE;
            ireq_valid_q <= launch_ok;
            ireq_addr_q  <= launch_pc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ibus.ireq_valid = ireq_valid_q;
  assign ibus.ireq_addr  = ireq_addr_q;
  assign out_valid       = out_valid_q;
  assign out_instr       = out_instr_q;
  assign out_pc          = out_pc_q;
endmodule
